// File: rtl/sdram_model_pkg.sv
// Shared command encoding, mode-register layout and geometry for the SDR SDRAM model.
package sdram_model_pkg;

  localparam int DEF_DW    = 16;
  localparam int DEF_ROW_W = 12;
  localparam int DEF_COL_W = 8;
  localparam int BA_W      = 2;
  localparam int NBANK     = 1 << BA_W;
  localparam int MAX_CL    = 3;

  // Values are the {ras_n, cas_n, we_n} pin encodings
  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_READ,
    B_WRITE
  } burst_e;

  typedef struct packed {
    logic [3:0] bl;         // burst length in beats: 1, 2, 4 or 8
    logic [1:0] cl;         // CAS latency: 2 or 3
    logic       wb_single;  // write bursts forced to a single beat
  } mode_t;

  localparam mode_t MODE_RESET = '{bl: 4'd1, cl: 2'd3, wb_single: 1'b0};

  function automatic logic mrs_valid(input logic [2:0] bl_f, input logic [2:0] cl_f);
    return (bl_f[2] == 1'b0) && ((cl_f == 3'd2) || (cl_f == 3'd3));
  endfunction

endpackage

// File: rtl/sdr_cas_pipe.sv
// Read-data CAS-latency pipeline with a fixed two-edge DQM output mask.
module sdr_cas_pipe
  import sdram_model_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int BW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic [BW-1:0] dqm_i,
  input  logic [1:0]    cl_i,
  output logic [DW-1:0] dq_o,
  output logic          oe_o
);

  logic [MAX_CL-1:0]         valid_q;
  logic [MAX_CL-1:0][DW-1:0] data_q;
  logic [1:0]                mask_q;
  logic                      sel_valid;
  logic [DW-1:0]             sel_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else if (en_i) begin
      mask_q <= {mask_q[0], |dqm_i};
      data_q <= {data_q[MAX_CL-2:0], data_i};
      if (flush_i) begin
        valid_q <= '0;
      end else begin
        valid_q <= {valid_q[MAX_CL-2:0], push_i};
      end
    end
  end

  // Stage k is loaded k edges after the push, so stage CL-1 drives the pins for edge N+CL
  always_comb begin
    sel_valid = (cl_i == 2'd2) ? valid_q[1] : valid_q[2];
    sel_data  = (cl_i == 2'd2) ? data_q[1]  : data_q[2];
    oe_o      = sel_valid && !mask_q[1];
    dq_o      = oe_o ? sel_data : '0;
  end

endmodule

// File: rtl/is42vm16400k_model.sv
// Behavioural SDR SDRAM model: command decode, bank/row tracking, burst engine and storage.
module is42vm16400k_model
  import sdram_model_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int BW    = DW / 8,
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W
) (
  input  logic             sdram_clk,
  input  logic             sdram_resetn,
  input  logic             sdr_cke,
  input  logic             sdr_cs_n,
  input  logic             sdr_ras_n,
  input  logic             sdr_cas_n,
  input  logic             sdr_we_n,
  input  logic [BA_W-1:0]  sdr_ba,
  input  logic [ROW_W-1:0] sdr_addr,
  input  logic [BW-1:0]    sdr_dqm,
  input  logic [DW-1:0]    sdr_dq_i,
  output logic [DW-1:0]    sdr_dq_o,
  output logic             sdr_dq_oe,
  output logic             err
);

  localparam int AW = BA_W + ROW_W + COL_W;

  logic [DW-1:0] mem [2**AW];

  mode_t                       mode_q, mode_d;
  logic [NBANK-1:0]            open_q, open_d;
  logic [NBANK-1:0][ROW_W-1:0] row_q, row_d;
  burst_e                      bst_q, bst_d;
  logic [BA_W-1:0]             bbank_q, bbank_d;
  logic [COL_W-1:0]            bcol_q, bcol_d;
  logic [3:0]                  beat_q, beat_d;
  logic [3:0]                  blen_q, blen_d;
  logic                        bap_q, bap_d;
  logic                        err_q, err_d;

  cmd_e             cmd;
  logic             is_rw, rw_ok, stop, cont;
  logic             cur_valid, cur_wr, cur_ap, cur_last;
  logic [BA_W-1:0]  cur_bank;
  logic [COL_W-1:0] cur_base, cur_col, cur_mask;
  logic [3:0]       cur_idx, cur_len;
  logic [AW-1:0]    cur_addr;
  logic             mem_we, rd_push, wr_flush;
  logic [DW-1:0]    rd_data;

  always_comb begin
    cmd = CMD_NOP;
    if (sdr_cke && !sdr_cs_n) begin
      cmd = cmd_e'({sdr_ras_n, sdr_cas_n, sdr_we_n});
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      mode_q  <= MODE_RESET;
      open_q  <= '0;
      row_q   <= '0;
      bst_q   <= B_IDLE;
      bbank_q <= '0;
      bcol_q  <= '0;
      beat_q  <= '0;
      blen_q  <= '0;
      bap_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (sdr_cke) begin
      mode_q  <= mode_d;
      open_q  <= open_d;
      row_q   <= row_d;
      bst_q   <= bst_d;
      bbank_q <= bbank_d;
      bcol_q  <= bcol_d;
      beat_q  <= beat_d;
      blen_q  <= blen_d;
      bap_q   <= bap_d;
      err_q   <= err_d;
    end
  end

  // The beat handled on this edge is either beat 0 of a new command or the next beat of the running burst
  always_comb begin
    is_rw = (cmd == CMD_READ) || (cmd == CMD_WRITE);
    rw_ok = is_rw && open_q[sdr_ba];
    stop  = is_rw || (cmd == CMD_BST) ||
            ((cmd == CMD_PRE) && (sdr_addr[10] || (sdr_ba == bbank_q)));
    cont  = (bst_q != B_IDLE) && !stop;
    cur_valid = rw_ok || cont;
    if (rw_ok) begin
      cur_wr   = (cmd == CMD_WRITE);
      cur_bank = sdr_ba;
      cur_base = sdr_addr[COL_W-1:0];
      cur_idx  = '0;
      cur_len  = ((cmd == CMD_WRITE) && mode_q.wb_single) ? 4'd1 : mode_q.bl;
      cur_ap   = sdr_addr[10];
    end else begin
      cur_wr   = (bst_q == B_WRITE);
      cur_bank = bbank_q;
      cur_base = bcol_q;
      cur_idx  = beat_q;
      cur_len  = blen_q;
      cur_ap   = bap_q;
    end
    cur_mask = COL_W'(cur_len - 4'd1);
    cur_col  = (cur_base & ~cur_mask) | ((cur_base + COL_W'(cur_idx)) & cur_mask);
    cur_last = (cur_idx == (cur_len - 4'd1));
    cur_addr = {cur_bank, row_q[cur_bank], cur_col};
    rd_data  = mem[cur_addr];
    mem_we   = sdr_cke && cur_valid && cur_wr;
    rd_push  = sdr_cke && cur_valid && !cur_wr;
    wr_flush = (cmd == CMD_WRITE);
  end

  always_comb begin
    mode_d  = mode_q;
    open_d  = open_q;
    row_d   = row_q;
    err_d   = 1'b0;
    bst_d   = B_IDLE;
    bbank_d = bbank_q;
    bcol_d  = bcol_q;
    beat_d  = beat_q;
    blen_d  = blen_q;
    bap_d   = bap_q;

    if (cur_valid && !cur_last) begin
      bst_d   = cur_wr ? B_WRITE : B_READ;
      bbank_d = cur_bank;
      bcol_d  = cur_base;
      beat_d  = cur_idx + 4'd1;
      blen_d  = cur_len;
      bap_d   = cur_ap;
    end
    if (cur_valid && cur_last && cur_ap) begin
      open_d[cur_bank] = 1'b0;
    end

    case (cmd)
      CMD_MRS: begin
        if (mrs_valid(sdr_addr[2:0], sdr_addr[6:4])) begin
          mode_d.bl        = 4'd1 << sdr_addr[1:0];
          mode_d.cl        = sdr_addr[5:4];
          mode_d.wb_single = sdr_addr[9];
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_ACT: begin
        if (open_q[sdr_ba]) begin
          err_d = 1'b1;
        end else begin
          open_d[sdr_ba] = 1'b1;
          row_d[sdr_ba]  = sdr_addr;
        end
      end
      CMD_PRE: begin
        if (sdr_addr[10]) begin
          open_d = '0;
        end else begin
          open_d[sdr_ba] = 1'b0;
        end
      end
      CMD_REF: begin
        if (|open_q) begin
          err_d = 1'b1;
        end
      end
      CMD_READ, CMD_WRITE: begin
        if (!open_q[sdr_ba]) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage has no reset; a reset aborts bursts because bank/burst state is cleared asynchronously
  always_ff @(posedge sdram_clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (!sdr_dqm[b]) begin
          mem[cur_addr][b*8 +: 8] <= sdr_dq_i[b*8 +: 8];
        end
      end
    end
  end

  sdr_cas_pipe #(
    .DW(DW),
    .BW(BW)
  ) u_cas_pipe (
    .clk_i   (sdram_clk),
    .rst_ni  (sdram_resetn),
    .en_i    (sdr_cke),
    .flush_i (wr_flush),
    .push_i  (rd_push),
    .data_i  (rd_data),
    .dqm_i   (sdr_dqm),
    .cl_i    (mode_q.cl),
    .dq_o    (sdr_dq_o),
    .oe_o    (sdr_dq_oe)
  );

  always_comb begin
    err = err_q;
  end

endmodule

// File: tb/tb_is42vm16400k_model.sv
// Directed bench for is42vm16400k_model: mode setup, bursts, masking, protocol errors and reset.
module tb_is42vm16400k_model;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;

  logic        clk;
  logic        rstn;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [11:0] addr;
  logic [1:0]  dqm;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        oe;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  is42vm16400k_model #(
    .DW   (16),
    .BW   (2),
    .ROW_W(12),
    .COL_W(8)
  ) dut (
    .sdram_clk   (clk),
    .sdram_resetn(rstn),
    .sdr_cke     (cke),
    .sdr_cs_n    (cs_n),
    .sdr_ras_n   (ras_n),
    .sdr_cas_n   (cas_n),
    .sdr_we_n    (we_n),
    .sdr_ba      (ba),
    .sdr_addr    (addr),
    .sdr_dqm     (dqm),
    .sdr_dq_i    (dq_i),
    .sdr_dq_o    (dq_o),
    .sdr_dq_oe   (oe),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one command for exactly one rising edge; returns at the following falling edge
  task automatic op(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                    input logic [1:0] m, input logic [15:0] d);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba   = b;
    addr = a;
    dqm  = m;
    dq_i = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop();
    op(C_NOP, 2'd0, 12'h000, 2'b00, 16'h0000);
  endtask

  initial begin
    rstn = 1'b0; cke = 1'b1; cs_n = 1'b1;
    ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = '0; addr = '0; dqm = '0; dq_i = '0;
    repeat (3) @(negedge clk);
    chk1("rst_oe", oe, 1'b0);
    chk16("rst_dq", dq_o, 16'h0000);
    chk1("rst_err", err, 1'b0);
    rstn = 1'b1;
    @(negedge clk);

    // CL=2, BL=2 write then read
    op(C_MRS, 2'd0, 12'h021, 2'b00, 16'h0000);   chk1("mrs21_err", err, 1'b0);
    op(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0000);   chk1("act_err", err, 1'b0);
    op(C_WR,  2'd1, 12'h010, 2'b00, 16'hA5A5);
    op(C_NOP, 2'd0, 12'h000, 2'b00, 16'h5A5A);
    op(C_RD,  2'd1, 12'h010, 2'b00, 16'h0000);   chk1("cl2_early_oe", oe, 1'b0);
    nop();  chk1("cl2_b0_oe", oe, 1'b1);  chk16("cl2_b0", dq_o, 16'hA5A5);
    nop();  chk1("cl2_b1_oe", oe, 1'b1);  chk16("cl2_b1", dq_o, 16'h5A5A);
    nop();  chk1("cl2_end_oe", oe, 1'b0); chk16("cl2_end_dq", dq_o, 16'h0000);

    // CL=3, BL=4 with sequential wrap
    op(C_MRS, 2'd0, 12'h032, 2'b00, 16'h0000);   chk1("mrs32_err", err, 1'b0);
    op(C_WR,  2'd1, 12'h006, 2'b00, 16'h0001);
    op(C_NOP, 2'd0, 12'h000, 2'b00, 16'h0002);
    op(C_NOP, 2'd0, 12'h000, 2'b00, 16'h0003);
    op(C_NOP, 2'd0, 12'h000, 2'b00, 16'h0004);
    op(C_RD,  2'd1, 12'h004, 2'b00, 16'h0000);
    nop();  chk1("cl3_early_oe", oe, 1'b0);
    nop();  chk16("wrap_b0", dq_o, 16'h0003);
    nop();  chk16("wrap_b1", dq_o, 16'h0004);
    nop();  chk16("wrap_b2", dq_o, 16'h0001);
    nop();  chk16("wrap_b3", dq_o, 16'h0002); chk1("wrap_b3_oe", oe, 1'b1);
    nop();  chk1("wrap_end_oe", oe, 1'b0);

    // Rejected mode, then byte-masked write at CL=2, BL=1
    op(C_MRS, 2'd0, 12'h027, 2'b00, 16'h0000);   chk1("mrs_bad_err", err, 1'b1);
    op(C_MRS, 2'd0, 12'h020, 2'b00, 16'h0000);   chk1("mrs20_err", err, 1'b0);
    op(C_WR,  2'd1, 12'h020, 2'b00, 16'hFFFF);
    op(C_WR,  2'd1, 12'h020, 2'b10, 16'h1234);
    op(C_RD,  2'd1, 12'h020, 2'b00, 16'h0000);
    nop();  chk1("bytemask_oe", oe, 1'b1); chk16("bytemask", dq_o, 16'hFF34);
    nop();  chk1("bl1_end_oe", oe, 1'b0);

    // Read DQM: mask raised two edges ahead of beat 1
    op(C_MRS, 2'd0, 12'h021, 2'b00, 16'h0000);
    op(C_RD,  2'd1, 12'h010, 2'b00, 16'h0000);
    op(C_NOP, 2'd0, 12'h000, 2'b11, 16'h0000);   chk1("dqm_b0_oe", oe, 1'b1); chk16("dqm_b0", dq_o, 16'hA5A5);
    op(C_NOP, 2'd0, 12'h000, 2'b00, 16'h0000);   chk1("dqm_b1_oe", oe, 1'b0); chk16("dqm_b1_dq", dq_o, 16'h0000);
    nop();

    // Closed-bank read and double ACT
    op(C_RD,  2'd2, 12'h010, 2'b00, 16'h0000);   chk1("rd_closed_err", err, 1'b1); chk1("rd_closed_oe0", oe, 1'b0);
    nop();  chk1("rd_closed_err_clr", err, 1'b0);
    nop();  chk1("rd_closed_oe", oe, 1'b0);
    op(C_ACT, 2'd1, 12'h005, 2'b00, 16'h0000);   chk1("act_open_err", err, 1'b1);
    nop();  chk1("act_open_err_clr", err, 1'b0);
    op(C_RD,  2'd1, 12'h020, 2'b00, 16'h0000);
    nop();  chk16("row_kept", dq_o, 16'hFF34);
    nop(); nop();

    // Auto-precharge, refresh rules
    op(C_RD,  2'd1, 12'h410, 2'b00, 16'h0000);
    nop();  chk16("ap_b0", dq_o, 16'hA5A5);
    nop();  chk16("ap_b1", dq_o, 16'h5A5A);
    op(C_RD,  2'd1, 12'h010, 2'b00, 16'h0000);   chk1("ap_closed_err", err, 1'b1);
    nop();
    op(C_ACT, 2'd0, 12'h001, 2'b00, 16'h0000);   chk1("act0_err", err, 1'b0);
    op(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0000);   chk1("act1_err", err, 1'b0);
    op(C_REF, 2'd0, 12'h000, 2'b00, 16'h0000);   chk1("ref_open_err", err, 1'b1);
    op(C_PRE, 2'd0, 12'h400, 2'b00, 16'h0000);   chk1("preall_err", err, 1'b0);
    op(C_REF, 2'd0, 12'h000, 2'b00, 16'h0000);   chk1("ref_err", err, 1'b0);
    op(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0000);
    op(C_RD,  2'd1, 12'h020, 2'b00, 16'h0000);
    nop();  chk16("ref_retain", dq_o, 16'hFF34);
    nop(); nop();

    // Reset in the middle of a read burst
    op(C_RD,  2'd1, 12'h010, 2'b00, 16'h0000);
    nop();  chk1("pre_rst_oe", oe, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("midrst_oe", oe, 1'b0);
    chk16("midrst_dq", dq_o, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    op(C_RD,  2'd1, 12'h010, 2'b00, 16'h0000);   chk1("postrst_err", err, 1'b1);
    op(C_ACT, 2'd1, 12'h123, 2'b00, 16'h0000);
    op(C_RD,  2'd1, 12'h010, 2'b00, 16'h0000);
    nop();  chk1("defcl3_early_oe", oe, 1'b0);
    nop();  chk1("defcl3_oe", oe, 1'b1); chk16("defcl3_b0", dq_o, 16'hA5A5);
    nop();  chk1("defbl1_end_oe", oe, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
